// File: rtl/sat_add_pipe.sv
// Two-stage pipelined saturating adder with valid/ready on both sides.
// Stage 1 registers operands and the raw sum; stage 2 clamps and produces flags.
module sat_add_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             neg,
  output logic             ov,
  input  logic             clr_sticky,
  output logic             ov_sticky
);

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MaxNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_out_q, s2_out_d;
  logic             s2_zr_q, s2_zr_d;
  logic             s2_neg_q, s2_neg_d;
  logic             s2_ov_q, s2_ov_d;

  logic             sticky_q, sticky_d;

  logic             s1_ready;
  logic             s2_ready;
  logic             pos_ov;
  logic             neg_ov;

  // Overflow is only possible when both operands share a sign that the sum lost.
  assign pos_ov = ~s1_a_q[WIDTH-1] & ~s1_b_q[WIDTH-1] &  s1_sum_q[WIDTH-1];
  assign neg_ov =  s1_a_q[WIDTH-1] &  s1_b_q[WIDTH-1] & ~s1_sum_q[WIDTH-1];

  always_comb begin
    s2_ready   = ~s2_valid_q | out_ready;
    s1_ready   = ~s1_valid_q | s2_ready;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sum_d   = s1_sum_q;
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    s2_zr_d    = s2_zr_q;
    s2_neg_d   = s2_neg_q;
    s2_ov_d    = s2_ov_q;
    sticky_d   = sticky_q;

    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = in1;
        s1_b_d   = in2;
        s1_sum_d = in1 + in2;
      end
    end

    // Stage-2 data only moves when a real result arrives, so a stalled output never changes.
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (pos_ov) begin
          s2_out_d = MaxPos;
          s2_zr_d  = 1'b0;
          s2_neg_d = 1'b0;
          s2_ov_d  = 1'b1;
        end else if (neg_ov) begin
          s2_out_d = MaxNeg;
          s2_zr_d  = 1'b0;
          s2_neg_d = 1'b1;
          s2_ov_d  = 1'b1;
        end else begin
          s2_out_d = s1_sum_q;
          s2_zr_d  = ~|s1_sum_q;
          s2_neg_d = s1_sum_q[WIDTH-1];
          s2_ov_d  = 1'b0;
        end
      end
    end

    if (s2_valid_q && out_ready && s2_ov_q) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
      s2_zr_q    <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_ov_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sum_q   <= s1_sum_d;
      s2_valid_q <= s2_valid_d;
      s2_out_q   <= s2_out_d;
      s2_zr_q    <= s2_zr_d;
      s2_neg_q   <= s2_neg_d;
      s2_ov_q    <= s2_ov_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready  = s1_ready;
  assign out_valid = s2_valid_q;
  assign out       = s2_out_q;
  assign zr        = s2_zr_q;
  assign neg       = s2_neg_q;
  assign ov        = s2_ov_q;
  assign ov_sticky = sticky_q;

endmodule
